// File: rtl/simon_pkg.sv
// Shared types and defaults for the colour game datapath.
package simon_pkg;

  typedef enum logic [1:0] {RED, GREEN, BLUE, YELLOW} colour_t;

  localparam int          MAX_ROUNDS_DEFAULT = 32;
  localparam logic [15:0] LFSR_TAPS          = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT       = 16'hACE1;

  // One-hot LED/button pattern for a colour.
  function automatic logic [3:0] colour_onehot(colour_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Speed-scaled periodic tick. The period shrinks by SPEED_STEP per speed
// level and is floored at MIN_PERIOD. The tick is registered, so it appears
// period cycles after the restart edge.
module pulse_timer #(
  parameter int BASE_PERIOD = 25_000_000,
  parameter int SPEED_STEP  = 2_500_000,
  parameter int MIN_PERIOD  = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] speed,
  input  logic       start,
  input  logic       load_speed,
  input  logic       stop,
  output logic       pulse
);

  localparam logic [25:0] BASE = 26'(BASE_PERIOD);
  localparam logic [25:0] STEP = 26'(SPEED_STEP);
  localparam logic [25:0] MINP = 26'(MIN_PERIOD);

  logic [25:0] dec;
  logic [25:0] period;
  logic [25:0] cnt;
  logic        running;

  // Period with clamp: never underflows below the floor.
  always_comb begin
    dec    = {23'd0, speed} * STEP;
    period = BASE - dec;
    if (dec >= BASE || (BASE - dec) < MINP)
      period = MINP;
  end

  // Counter and tick; stop beats start, start/load_speed restart the count.
  always_ff @(posedge clk) begin
    if (reset || stop) begin
      running <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else if (load_speed) begin
      cnt     <= '0;
      pulse   <= 1'b0;
    end else if (running) begin
      if (cnt == period - 26'd1) begin
        cnt   <= '0;
        pulse <= 1'b1;
      end else begin
        cnt   <= cnt + 26'd1;
        pulse <= 1'b0;
      end
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/colour_sequencer.sv
// Colour game datapath: LFSR colour source, sequence storage, LED drive,
// press compare and speed-scaled pulse timer.
// Build option FIXED_SEED_EN: LFSR steps only on load_colour, giving a
// deterministic colour sequence from SEED; otherwise it free-runs.
module colour_sequencer
  import simon_pkg::*;
#(
  parameter int          MAX_ROUNDS  = MAX_ROUNDS_DEFAULT,
  parameter int          BASE_PERIOD = 25_000_000,
  parameter int          SPEED_STEP  = 2_500_000,
  parameter int          MIN_PERIOD  = 5_000_000,
  parameter logic [15:0] SEED        = SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_seedgen,
  input  logic       start,
  input  logic       load_colour,
  input  logic       load_speed,
  input  logic       flash_clk,
  input  logic [2:0] speed,
  input  logic [5:0] check_round,
  input  logic [5:0] current_round,
  input  logic [3:0] player_input,
  output logic       pulse,
  output logic       result,
  output logic [3:0] led,
  output logic [5:0] seq_len
);

  localparam int         AW      = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
  localparam logic [5:0] MAX_LEN = 6'(MAX_ROUNDS);

  colour_t     mem [MAX_ROUNDS];
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        lfsr_adv;
  logic [3:0]  press_q;
  logic        wr_en;
  logic [5:0]  idx;
  logic        idx_vld;
  colour_t     exp_colour;
  logic [3:0]  exp_oh;

`ifdef FIXED_SEED_EN
  assign lfsr_adv = load_colour;
`else
  assign lfsr_adv = 1'b1;
`endif

  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  assign wr_en     = load_colour && !rst_seedgen && (seq_len < MAX_LEN);

  // Galois LFSR; reseed has priority over stepping.
  always_ff @(posedge clk) begin
    if (reset || rst_seedgen)
      lfsr <= SEED;
    else if (lfsr_adv)
      lfsr <= lfsr_next;
  end

  // Sequence length: saturates at MAX_ROUNDS, no wrap.
  always_ff @(posedge clk) begin
    if (reset || rst_seedgen)
      seq_len <= '0;
    else if (wr_en)
      seq_len <= seq_len + 6'd1;
  end

  // Storage write; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (!reset && wr_en)
      mem[seq_len[AW-1:0]] <= colour_t'(lfsr[1:0]);
  end

  // Expected-colour lookup; only trusted when the index is in range.
  always_comb begin
    idx        = current_round - check_round;
    idx_vld    = (check_round != 6'd0) && (check_round <= current_round)
                 && (idx < seq_len);
    exp_colour = mem[idx[AW-1:0]];
    exp_oh     = colour_onehot(exp_colour);
  end

  // Press latch: holds last nonzero button pattern until cleared.
  always_ff @(posedge clk) begin
    if (reset || rst_seedgen || load_colour)
      press_q <= '0;
    else if (player_input != 4'd0)
      press_q <= player_input;
  end

  // Registered LED drive and compare result.
  always_ff @(posedge clk) begin
    if (reset) begin
      led    <= '0;
      result <= 1'b0;
    end else begin
      led    <= (flash_clk && idx_vld) ? exp_oh : 4'd0;
      result <= idx_vld && $onehot(press_q) && (press_q == exp_oh);
    end
  end

  pulse_timer #(
    .BASE_PERIOD (BASE_PERIOD),
    .SPEED_STEP  (SPEED_STEP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .speed      (speed),
    .start      (start),
    .load_speed (load_speed),
    .stop       (rst_seedgen),
    .pulse      (pulse)
  );

endmodule

// File: tb/tb_colour_sequencer.sv
// Scoreboard bench for colour_sequencer: the driver queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_colour_sequencer;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset, rst_seedgen, start, load_colour, load_speed, flash_clk;
  logic [2:0] speed;
  logic [5:0] check_round, current_round;
  logic [3:0] player_input;
  logic       pulse, result;
  logic [3:0] led;
  logic [5:0] seq_len;

  always #5 clk = ~clk;

  colour_sequencer #(
    .MAX_ROUNDS (32), .BASE_PERIOD (20), .SPEED_STEP (4),
    .MIN_PERIOD (6),  .SEED (SEED)
  ) dut (
    .clk (clk), .reset (reset), .rst_seedgen (rst_seedgen), .start (start),
    .load_colour (load_colour), .load_speed (load_speed),
    .flash_clk (flash_clk), .speed (speed), .check_round (check_round),
    .current_round (current_round), .player_input (player_input),
    .pulse (pulse), .result (result), .led (led), .seq_len (seq_len)
  );

  // Reference model of the colour store.
  logic [15:0] m_lfsr;
  logic [1:0]  m_mem [32];
  int          m_len;

  always @(posedge clk) begin
    bit adv;
`ifdef FIXED_SEED_EN
    adv = load_colour;
`else
    adv = 1'b1;
`endif
    if (reset || rst_seedgen) begin
      m_lfsr <= SEED;
      m_len  <= 0;
    end else begin
      if (adv) m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      if (load_colour && m_len < 32) begin
        m_mem[m_len] <= m_lfsr[1:0];
        m_len        <= m_len + 1;
      end
    end
  end

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  // Scoreboard: sel 0=pulse 1=result 2=led 3=seq_len
  typedef struct {
    string      name;
    int         sel;
    logic [5:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t       e;
      logic [5:0] act;
      e = q.pop_front();
      case (e.sel)
        0:       act = {5'd0, pulse};
        1:       act = {5'd0, result};
        2:       act = {2'd0, led};
        default: act = seq_len;
      endcase
      n_tot++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
    end
  end

  task automatic push(input string name, input int sel, input logic [5:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] p);
    player_input = p;
    step();
    player_input = 4'd0;
    step();
  endtask

  // Run n cycles checking the pulse lands every per cycles (0: never).
  task automatic pulses(input string name, input int n, input int per);
    for (int k = 1; k <= n; k++) begin
      step();
      push(name, 0, {5'd0, (per != 0) && (k % per == 0)});
    end
  endtask

  initial begin
    reset = 1'b1; rst_seedgen = 0; start = 0; load_colour = 0; load_speed = 0;
    flash_clk = 0; speed = 3'd0; check_round = 6'd0; current_round = 6'd0;
    player_input = 4'd0;
    step(); step();
    push("rst_pulse", 0, 6'd0);
    push("rst_result", 1, 6'd0);
    push("rst_led", 2, 6'd0);
    push("rst_len", 3, 6'd0);
    reset = 1'b0;

    // Seed and two colours.
    rst_seedgen = 1'b1; step(); rst_seedgen = 1'b0;
    load_colour = 1'b1; step(); step(); load_colour = 1'b0;
    push("len2", 3, 6'(m_len));
    push("len2_abs", 3, 6'd2);
`ifdef FIXED_SEED_EN
    push("fixed_mem0", 2, {2'd0, oh(m_mem[0])});
`endif
    current_round = 6'd2; check_round = 6'd2; flash_clk = 1'b1; step();
    push("led_idx0", 2, {2'd0, oh(m_mem[0])});
    check_round = 6'd1; step();
    push("led_idx1", 2, {2'd0, oh(m_mem[1])});

    // Press compare.
    check_round = 6'd2;
    press(oh(m_mem[0]));
    push("res_match0", 1, 6'd1);
    step();
    push("res_hold", 1, 6'd1);
    press(4'b0011);
    push("res_multi", 1, 6'd0);
    check_round = 6'd1;
    press(oh(m_mem[1]));
    push("res_match1", 1, 6'd1);
    press(oh(m_mem[1] + 2'd1));
    push("res_wrong", 1, 6'd0);

    // Invalid index with a latched press that matches idx 0.
    check_round = 6'd2;
    press(oh(m_mem[0]));
    push("res_pre_inv", 1, 6'd1);
    check_round = 6'd0; step();
    push("led_cr0", 2, 6'd0);
    push("res_cr0", 1, 6'd0);
    check_round = 6'd3; step();
    push("led_cr_gt", 2, 6'd0);
    push("res_cr_gt", 1, 6'd0);
    current_round = 6'd5; check_round = 6'd2; step();
    push("led_idx_oob", 2, 6'd0);
    push("res_idx_oob", 1, 6'd0);
    current_round = 6'd2; step();
    push("res_back", 1, 6'd1);
    load_colour = 1'b1; step(); load_colour = 1'b0; step();
    push("res_latch_clr", 1, 6'd0);
    push("len3", 3, 6'd3);

    // Pulse timing.
    flash_clk = 1'b0;
    speed = 3'd0; start = 1'b1; step(); start = 1'b0;
    push("pls_start", 0, 6'd0);
    pulses("pls_p20", 40, 20);
    speed = 3'd2; load_speed = 1'b1; step(); load_speed = 1'b0;
    push("pls_ld2", 0, 6'd0);
    pulses("pls_p12", 24, 12);
    speed = 3'd7; load_speed = 1'b1; step(); load_speed = 1'b0;
    pulses("pls_p6", 12, 6);
    rst_seedgen = 1'b1; step(); rst_seedgen = 1'b0;
    push("pls_stop0", 0, 6'd0);
    push("len_seedclr", 3, 6'd0);
    pulses("pls_stopped", 30, 0);

    // Full storage.
    load_colour = 1'b1;
    for (int i = 0; i < 33; i++) step();
    load_colour = 1'b0;
    push("len_sat", 3, 6'd32);
    current_round = 6'd32; check_round = 6'd1; flash_clk = 1'b1; step();
    push("led_mem31", 2, {2'd0, oh(m_mem[31])});

    // Reset mid-operation.
    rst_seedgen = 1'b1; step(); rst_seedgen = 1'b0;
    load_colour = 1'b1; for (int i = 0; i < 5; i++) step(); load_colour = 1'b0;
    push("len5", 3, 6'd5);
    current_round = 6'd5; check_round = 6'd5;
    speed = 3'd7; start = 1'b1; step(); start = 1'b0;
    step(); step();
    push("led_pre_rst", 2, {2'd0, oh(m_mem[0])});
    reset = 1'b1; step(); reset = 1'b0;
    push("mid_pulse", 0, 6'd0);
    push("mid_led", 2, 6'd0);
    push("mid_len", 3, 6'd0);
    pulses("mid_no_pulse", 20, 0);
    start = 1'b1; step(); start = 1'b0;
    pulses("mid_restart", 6, 6);

    step();
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_tot++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
